// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci LFSR with seed load, lock-up recovery and wrap pulse.
// Optional period measurement output enabled by defining LFSR_PERIOD_CNT_EN.
module lfsr_gen #(
  parameter int             W     = 6,
  parameter logic [W-1:0]   TAPS  = 6'b110000,
  parameter int             XNOR  = 1,
  parameter int             STEPS = 1,
  parameter logic [W-1:0]   SEED  = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] seed_in,
  output logic [W-1:0] y,
  output logic         lock,
  output logic         wrap
`ifdef LFSR_PERIOD_CNT_EN
  ,
  output logic [W-1:0] period
`endif
);

  localparam logic [W-1:0] LOCK = (XNOR != 0) ? '1 : '0;

  if (W < 3 || W > 32) begin : g_bad_width
    $error("lfsr_gen: W must be in 3..32");
  end
  if (STEPS < 1 || STEPS > W) begin : g_bad_steps
    $error("lfsr_gen: STEPS must be in 1..W");
  end
  if (SEED == LOCK) begin : g_bad_seed
    $error("lfsr_gen: SEED equals the lock-up state");
  end

  function automatic logic [W-1:0] shift1(input logic [W-1:0] s);
    logic fb;
    fb = ^(s & TAPS);
    if (XNOR != 0) fb = ~fb;
    return {s[W-2:0], fb};
  endfunction

  logic [W-1:0] nxt;

  // STEPS single shifts chained combinationally so one clock equals STEPS clocks of STEPS=1.
  always_comb begin
    nxt = y;
    for (int i = 0; i < STEPS; i++) nxt = shift1(nxt);
  end

`ifdef LFSR_PERIOD_CNT_EN
  logic [W-1:0] cnt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y    <= SEED;
      lock <= 1'b0;
      wrap <= 1'b0;
`ifdef LFSR_PERIOD_CNT_EN
      cnt    <= '0;
      period <= '0;
`endif
    end else begin
      lock <= 1'b0;
      wrap <= 1'b0;
      if (load) begin
        y <= seed_in;
`ifdef LFSR_PERIOD_CNT_EN
        cnt <= '0;
`endif
      end else if (en && (y == LOCK)) begin
        y    <= SEED;
        lock <= 1'b1;
`ifdef LFSR_PERIOD_CNT_EN
        cnt <= '0;
`endif
      end else if (en) begin
        y    <= nxt;
        wrap <= (nxt == SEED);
`ifdef LFSR_PERIOD_CNT_EN
        if (nxt == SEED) begin
          period <= cnt + W'(1);
          cnt    <= '0;
        end else begin
          cnt <= cnt + W'(1);
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed self-checking bench for lfsr_gen: a STEPS=1 and a STEPS=2 instance
// with default taps, checked against hand-computed vectors and a single-shift reference.
module tb_lfsr_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic       en2 = 1'b0;
  logic [5:0] seed_in = '0;
  logic [5:0] y, y2;
  logic       lock, wrap, lock2, wrap2;
`ifdef LFSR_PERIOD_CNT_EN
  logic [5:0] period, period2;
`endif

  int checks = 0;
  int errors = 0;

  lfsr_gen dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .seed_in(seed_in),
    .y(y), .lock(lock), .wrap(wrap)
`ifdef LFSR_PERIOD_CNT_EN
    , .period(period)
`endif
  );

  lfsr_gen #(.STEPS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en2), .load(1'b0), .seed_in(6'b000000),
    .y(y2), .lock(lock2), .wrap(wrap2)
`ifdef LFSR_PERIOD_CNT_EN
    , .period(period2)
`endif
  );

  always #5 clk = ~clk;

  // Reference single shift for x^6+x^5+1 with XNOR feedback.
  function automatic logic [5:0] ref_step(input logic [5:0] s);
    return {s[4:0], ~(s[5] ^ s[4])};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic en_v, input logic load_v, input logic [5:0] seed_v);
    en      = en_v;
    load    = load_v;
    seed_in = seed_v;
    tick();
  endtask

  logic [5:0] exp1 [6];
  logic [5:0] exp2 [3];
  logic [5:0] model1, model2;
  logic       seen [64];

  initial begin
    exp1 = '{6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3E};
    exp2 = '{6'h03, 6'h0F, 6'h3E};
    for (int k = 0; k < 64; k++) seen[k] = 1'b0;

    // Reset state while rst_n is held low.
    #3;
    checkOutput("reset_y", y, 6'h00);
    checkOutput("reset_lock", lock, 0);
    checkOutput("reset_wrap", wrap, 0);
    checkOutput("reset_y2", y2, 6'h00);
`ifdef LFSR_PERIOD_CNT_EN
    checkOutput("reset_period", period, 0);
`endif
    #9;
    rst_n = 1'b1;
    en    = 1'b1;
    en2   = 1'b1;

    // Free run: table, wrap spacing, distinct states, STEPS=2 against doubled reference.
    model1 = 6'h00;
    model2 = 6'h00;
    for (int i = 1; i <= 200; i++) begin
      tick();
      model1 = ref_step(model1);
      model2 = ref_step(ref_step(model2));
      if (i <= 6) checkOutput("seq1_table", y, exp1[i-1]);
      if (i <= 3) checkOutput("seq2_table", y2, exp2[i-1]);
      checkOutput("run_y", y, model1);
      checkOutput("run_wrap", wrap, (i % 63 == 0));
      checkOutput("run_lock", lock, 0);
      checkOutput("run_y2", y2, model2);
      checkOutput("run_wrap2", wrap2, (model2 == 6'h00));
      if (i <= 63) begin
        checkOutput("distinct", seen[y], 0);
        seen[y] = 1'b1;
      end
`ifdef LFSR_PERIOD_CNT_EN
      if (i == 62) checkOutput("period_before_wrap", period, 0);
      if (i == 63) checkOutput("period_first_wrap", period, 63);
`endif
    end
    en2 = 1'b0;

    // Load the lock-up value, then recover on the next enabled clock.
    applyStimulus(1'b0, 1'b1, 6'h3F);
    checkOutput("load_lock_y", y, 6'h3F);
    checkOutput("load_lock_flag", lock, 0);
    applyStimulus(1'b1, 1'b0, 6'h00);
    checkOutput("recover_y", y, 6'h00);
    checkOutput("recover_lock", lock, 1);
    checkOutput("recover_wrap", wrap, 0);
    applyStimulus(1'b1, 1'b0, 6'h00);
    checkOutput("resume_y1", y, 6'h01);
    checkOutput("lock_one_cycle", lock, 0);
    applyStimulus(1'b1, 1'b0, 6'h00);
    checkOutput("resume_y2", y, 6'h03);
`ifdef LFSR_PERIOD_CNT_EN
    checkOutput("period_kept", period, 63);
`endif

    // Load has priority over en; then en toggling freezes y on en=0 clocks.
    applyStimulus(1'b1, 1'b1, 6'h2A);
    checkOutput("load_prio_y", y, 6'h2A);
    checkOutput("load_prio_wrap", wrap, 0);
    applyStimulus(1'b0, 1'b0, 6'h00);
    checkOutput("hold_a", y, 6'h2A);
    applyStimulus(1'b1, 1'b0, 6'h00);
    checkOutput("step_a", y, 6'h14);
    applyStimulus(1'b0, 1'b0, 6'h00);
    checkOutput("hold_b", y, 6'h14);
    checkOutput("hold_lock", lock, 0);
    applyStimulus(1'b1, 1'b0, 6'h00);
    checkOutput("step_b", y, 6'h28);
    applyStimulus(1'b0, 1'b0, 6'h00);
    checkOutput("hold_c", y, 6'h28);

    // Asynchronous reset pulse between edges.
    en = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_y", y, 6'h00);
    checkOutput("async_lock", lock, 0);
    checkOutput("async_wrap", wrap, 0);
`ifdef LFSR_PERIOD_CNT_EN
    checkOutput("async_period", period, 0);
`endif
    #2;
    rst_n = 1'b1;
    tick();
    checkOutput("post_reset_y", y, 6'h01);
    tick();
    checkOutput("post_reset_y2", y, 6'h03);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lfsr_gen.md
Name: lfsr_gen

Overview:
Parametrised Fibonacci LFSR pseudo-random generator. It is the next generation of the fixed 6-bit XNOR LFSR and generalises width, tap set, feedback polarity and bits advanced per clock. It adds seed load, clock enable, lock-up recovery and wrap detection. It serves as the PN/dither/test-pattern source for DSP datapaths.

Parameters:
W, 6, state/output width in bits; legal range 3..32.
TAPS, 6'b110000, feedback mask of width W; bit k=1 selects state bit k. The default is x^6+x^5+1.
XNOR, 1, feedback polarity: 1 = XNOR (lock-up state all-ones), 0 = XOR (lock-up state all-zeros).
STEPS, 1, single-bit shifts applied per enabled clock; legal range 1..W.
SEED, 0, reset and recovery state. Must not equal the lock-up state; elaboration error if it does.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
en  in  1  advance the state by STEPS shifts this clock.
load  in  1  load seed_in this clock; priority over en.
seed_in  in  W  value loaded when load=1.
y  out  W  current LFSR state, registered.
lock  out  1  one-cycle pulse: lock-up state was detected and replaced by SEED.
wrap  out  1  one-cycle pulse: state re-entered SEED by stepping.

Behaviour:
- Reset (rst_n=0, async): y=SEED, lock=0, wrap=0. Outputs are held while rst_n is low. Release is synchronous-safe, with the first possible step on the first rising edge after deassertion.
- Single shift s -> s': s'[k]=s[k-1] for k=W-1..1; s'[0]=^(s & TAPS), inverted when XNOR=1. State bits travel from bit 0 toward bit W-1.
- Enabled clock: the next state is STEPS single shifts composed combinationally, so results are identical to STEPS separate clocks with STEPS=1. Latency is 1 clock from en to the new y.
- Priority each clock: load > lock-up recovery > en step > hold.
- load=1: y<=seed_in, no step, lock=0, wrap=0. Loading the lock-up value is allowed; it is recovered on the next en clock.
- Lock-up: en=1 and y==LOCK (all-ones if XNOR, else all-zeros) -> y<=SEED, lock=1 next cycle, wrap=0. No step that cycle.
- wrap: registered pulse, high for the cycle after a normal en step produced y==SEED. Not raised by reset, load or lock recovery. With STEPS>1, only states on clock boundaries are compared.
- en=0 and load=0: y holds, lock=0, wrap=0.
- Period for a primitive TAPS set is 2^W-1 single shifts, so wrap recurs every (2^W-1)/gcd(STEPS,2^W-1) enabled clocks.
- No X propagation: y is always a defined W-bit value after reset.

Optional Feature:
Macro LFSR_PERIOD_CNT_EN.
- Defined: adds output period (W bits, reset 0) and an internal W-bit clock counter cnt (reset 0).
  - cnt increments on each enabled normal step.
  - On the step that raises wrap, period<=cnt+1 and cnt<=0.
  - load, lock recovery and reset clear cnt without updating period.
- Not defined: neither the port nor the counter exists, and all other behaviour is unchanged.

Test Plan:
- Reset, defaults (W=6, TAPS=110000, XNOR, SEED=0), en=1 for 6 clocks -> y = 000001, 000011, 000111, 001111, 011111, 111110.
- Defaults, en=1 held -> wrap pulses exactly every 63 clocks, with no repeated state in between. With LFSR_PERIOD_CNT_EN, period=63 after the first wrap.
- STEPS=2, otherwise defaults, en=1 from reset -> y = 000011, 001111, 111110. A STEPS=1 model sampled on every second clock matches for 200 clocks.
- load=1 with seed_in=111111, then en=1 -> next y=000000 with lock=1 for exactly one cycle and wrap=0. Stepping then resumes as in the first test.
- en=1 and load=1 together with seed_in=101010 -> y=101010 with no step. en toggled 0/1 -> y frozen on every en=0 cycle.
- rst_n pulsed low mid-sequence between clock edges -> y=SEED immediately. lock and wrap are 0, and the period counter is cleared if present.
